pipe_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the core, generalising the fixed five-stage stall priority encoder to NUM_STAGES stages. It turns per-stage stall requests into a thermometer freeze vector, and per-stage redirect requests into younger-stage flush masks. Redirects raised by a frozen stage are held pending until that stage is released. A stall watchdog flags a pipeline stuck in stall, and optional performance counters track stall and flush activity.

---
 rtl/pipe_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall thermometer, deferred redirects, flush hold, stall watchdog.
// Optional stall/flush performance counters are built when CTRL_PERF_CNT_EN is defined.
module pipe_ctrl #(
    parameter int NUM_STAGES = 5,
    parameter int FLUSH_HOLD = 1,
    parameter int WDT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stall_req_i,
    input  logic [NUM_STAGES-1:0] flush_req_i,
    input  logic                  wdt_clr_i,
    output logic [NUM_STAGES-1:0] stalled_o,
    output logic [NUM_STAGES-1:0] flush_o,
    output logic                  flush_pending_o,
    output logic                  stall_timeout_o,
    output logic [31:0]           stall_cycles_o,
    output logic [31:0]           flush_count_o
);

    localparam int HW = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(FLUSH_HOLD - 1);

    logic [NUM_STAGES-1:0] stall_vec;
    logic [NUM_STAGES-1:0] eff;
    logic [NUM_STAGES-1:0] mask;
    logic [NUM_STAGES-1:0] pend_q, pend_d;
    logic [NUM_STAGES-1:0] hold_mask_q;
    logic [HW-1:0]         hold_cnt_q;
    logic [WDT_WIDTH-1:0]  wdt_q;
    logic                  timeout_q;
    logic                  wdt_inc;
    logic                  wdt_set;
    logic                  unused_flush0;

    // Stage 0 never resolves a redirect.
    assign unused_flush0 = flush_req_i[0];

    always_comb begin
        stall_vec = '0;
        for (int j = 0; j < NUM_STAGES; j++)
            for (int k = j; k < NUM_STAGES; k++)
                if (stall_req_i[k]) stall_vec[j] = 1'b1;

        eff = '0;
        for (int k = 1; k < NUM_STAGES; k++)
            eff[k] = (flush_req_i[k] | pend_q[k]) & ~stall_vec[k];

        mask = '0;
        for (int j = 0; j < NUM_STAGES - 1; j++)
            for (int k = j + 1; k < NUM_STAGES; k++)
                if (eff[k]) mask[j] = 1'b1;

        pend_d = pend_q;
        pend_d[0] = 1'b0;
        for (int k = 1; k < NUM_STAGES; k++) begin
            if (eff[k])
                pend_d[k] = 1'b0;
            else if (flush_req_i[k] && stall_vec[k])
                pend_d[k] = 1'b1;
        end
    end

    // Reset forces a full freeze and suppresses kills without waiting for a clock.
    assign stalled_o       = rst ? stall_vec : '1;
    assign flush_o         = rst ? (mask | hold_mask_q) : '0;
    assign flush_pending_o = |pend_q;
    assign stall_timeout_o = timeout_q;

    assign wdt_inc = (|stall_vec) && (mask == '0) && (wdt_q != '1);
    assign wdt_set = wdt_inc && ((wdt_q + 1'b1) == '1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q      <= '0;
            hold_mask_q <= '0;
            hold_cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            if (mask != '0) begin
                if (FLUSH_HOLD > 1) begin
                    hold_mask_q <= mask | hold_mask_q;
                    hold_cnt_q  <= HOLD_LOAD;
                end
            end else if (hold_cnt_q != '0) begin
                hold_cnt_q <= hold_cnt_q - 1'b1;
                if (hold_cnt_q == HW'(1)) hold_mask_q <= '0;
            end
        end
    end

    // A set in the same cycle as a clear leaves the flag high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (!(|stall_vec) || wdt_clr_i)
                wdt_q <= '0;
            else if (wdt_inc)
                wdt_q <= wdt_q + 1'b1;

            if (wdt_set)
                timeout_q <= 1'b1;
            else if (wdt_clr_i)
                timeout_q <= 1'b0;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (|stall_vec) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (mask != '0) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign flush_count_o  = flush_cnt_q;
`else
    assign stall_cycles_o = '0;
    assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl (5 stages, hold 2, 4-bit watchdog): directed scenarios plus random traffic
// compared cycle by cycle against a behavioural model of the hazard rules.
module tb_pipe_ctrl;

    localparam int N   = 5;
    localparam int FH  = 2;
    localparam int WMAX = 15;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] stall_req_i = '0;
    logic [N-1:0] flush_req_i = '0;
    logic         wdt_clr_i = 1'b0;
    logic [N-1:0] stalled_o, flush_o;
    logic         flush_pending_o, stall_timeout_o;
    logic [31:0]  stall_cycles_o, flush_count_o;

    pipe_ctrl #(.NUM_STAGES(N), .FLUSH_HOLD(FH), .WDT_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .stall_req_i(stall_req_i), .flush_req_i(flush_req_i), .wdt_clr_i(wdt_clr_i),
        .stalled_o(stalled_o), .flush_o(flush_o),
        .flush_pending_o(flush_pending_o), .stall_timeout_o(stall_timeout_o),
        .stall_cycles_o(stall_cycles_o), .flush_count_o(flush_count_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model state
    logic [N-1:0] m_pend, m_hmask;
    int           m_hleft, m_wdt;
    logic         m_to;
    logic [31:0]  m_sc, m_fc;

    // Last observed outputs, for directed spot checks
    logic [N-1:0] o_st, o_fl;
    logic         o_pend, o_to;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_hmask = '0; m_hleft = 0; m_wdt = 0; m_to = 1'b0;
        m_sc = '0; m_fc = '0;
    endtask

    // One cycle: drive, compare before the edge, advance the model across the edge.
    task automatic step(input logic [N-1:0] s, input logic [N-1:0] f, input logic c);
        int h;
        logic [N-1:0] e_st, e_mask;
        logic set;
        stall_req_i = s; flush_req_i = f; wdt_clr_i = c;
        #2;
        h = -1;
        for (int k = 0; k < N; k++) if (s[k]) h = k;
        e_st = (h < 0) ? '0 : N'((1 << (h + 1)) - 1);
        e_mask = '0;
        for (int k = 1; k < N; k++)
            if ((f[k] | m_pend[k]) && !e_st[k]) e_mask = e_mask | N'((1 << k) - 1);

        o_st = stalled_o; o_fl = flush_o; o_pend = flush_pending_o; o_to = stall_timeout_o;
        check("stalled", {27'd0, stalled_o}, {27'd0, e_st});
        check("flush", {27'd0, flush_o}, {27'd0, e_mask | m_hmask});
        check("pending", {31'd0, flush_pending_o}, {31'd0, |m_pend});
        check("timeout", {31'd0, stall_timeout_o}, {31'd0, m_to});
`ifdef CTRL_PERF_CNT_EN
        check("stall_cycles", stall_cycles_o, m_sc);
        check("flush_count", flush_count_o, m_fc);
`else
        check("stall_cycles", stall_cycles_o, 32'd0);
        check("flush_count", flush_count_o, 32'd0);
`endif
        @(posedge clk);
        #1;
        for (int k = 1; k < N; k++) begin
            if ((f[k] | m_pend[k]) && !e_st[k]) m_pend[k] = 1'b0;
            else if (f[k] && e_st[k]) m_pend[k] = 1'b1;
        end
        if (e_mask != 0) begin
            if (FH > 1) begin
                m_hmask = m_hmask | e_mask;
                m_hleft = FH - 1;
            end
        end else if (m_hleft > 0) begin
            m_hleft--;
            if (m_hleft == 0) m_hmask = '0;
        end
        set = 1'b0;
        if (e_st == 0) m_wdt = 0;
        else if (e_mask == 0 && m_wdt < WMAX) begin
            m_wdt++;
            set = (m_wdt == WMAX);
        end
        if (c) m_wdt = 0;
        if (set) m_to = 1'b1;
        else if (c) m_to = 1'b0;
        if (e_st != 0) m_sc = m_sc + 32'd1;
        if (e_mask != 0) m_fc = m_fc + 32'd1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b0);
    endtask

    initial begin
        model_reset();
        #1;
        check("rst_stalled", {27'd0, stalled_o}, 32'h1f);
        check("rst_flush", {27'd0, flush_o}, 32'h0);
        check("rst_timeout", {31'd0, stall_timeout_o}, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst = 1'b1;

        // Priority encoding
        step(5'b00101, '0, 1'b0); check("prio_a", {27'd0, o_st}, 32'h07);
        step(5'b10000, '0, 1'b0); check("prio_b", {27'd0, o_st}, 32'h1f);
        step(5'b00000, '0, 1'b0); check("prio_c", {27'd0, o_st}, 32'h00);

        // Plain redirect with hold
        step('0, 5'b00100, 1'b0); check("plain_c0", {27'd0, o_fl}, 32'h03);
        step('0, '0, 1'b0);       check("plain_c1", {27'd0, o_fl}, 32'h03);
        step('0, '0, 1'b0);       check("plain_c2", {27'd0, o_fl}, 32'h00);
        idle(2);

        // Deferred redirect
        step(5'b01000, 5'b00100, 1'b0); check("defer_c1", {27'd0, o_fl}, 32'h00);
        step(5'b01000, '0, 1'b0);       check("defer_p2", {31'd0, o_pend}, 32'h1);
        step(5'b01000, '0, 1'b0);       check("defer_p3", {31'd0, o_pend}, 32'h1);
        step('0, '0, 1'b0);             check("defer_f4", {27'd0, o_fl}, 32'h03);
        step('0, '0, 1'b0);             check("defer_p5", {31'd0, o_pend}, 32'h0);
        idle(2);

        // Overlapping redirects
        step('0, 5'b00100, 1'b0); check("ovl_c0", {27'd0, o_fl}, 32'h03);
        step('0, 5'b01000, 1'b0); check("ovl_c1", {27'd0, o_fl}, 32'h07);
        step('0, '0, 1'b0);       check("ovl_c2", {27'd0, o_fl}, 32'h07);
        step('0, '0, 1'b0);       check("ovl_c3", {27'd0, o_fl}, 32'h00);
        idle(1);

        // Watchdog
        for (int i = 0; i < 15; i++) step(5'b00001, '0, 1'b0);
        check("wdt_not_early", {31'd0, o_to}, 32'h0);
        step('0, '0, 1'b0); check("wdt_set", {31'd0, o_to}, 32'h1);
        step('0, '0, 1'b0); check("wdt_sticky", {31'd0, o_to}, 32'h1);
        step('0, '0, 1'b1);
        step('0, '0, 1'b0); check("wdt_clr", {31'd0, o_to}, 32'h0);

        // Reset during the flush hold cycle
        step('0, 5'b00100, 1'b0);
        stall_req_i = '0; flush_req_i = '0; wdt_clr_i = 1'b0;
        #2;
        check("mid_hold_flush", {27'd0, flush_o}, 32'h03);
        rst = 1'b0;
        #1;
        check("mid_rst_flush", {27'd0, flush_o}, 32'h00);
        check("mid_rst_stalled", {27'd0, stalled_o}, 32'h1f);
        model_reset();
        @(posedge clk); #3;
        rst = 1'b1;
        step('0, '0, 1'b0); check("post_rst_flush", {27'd0, o_fl}, 32'h00);
        check("post_rst_to", {31'd0, o_to}, 32'h0);

        // Random traffic with periodic long stall bursts
        for (int i = 0; i < 600; i++) begin
            logic [N-1:0] s, f;
            logic c;
            if (i % 150 == 20) begin
                for (int b = 0; b < 17; b++) step(5'b00010, '0, 1'b0);
            end
            s = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            f = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            c = ($urandom_range(0, 19) == 0);
            step(s, f, c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
